// File: rtl/axi_node_pkg.sv
// Shared types and helpers for the AXI node response path.
package axi_node_pkg;

    localparam int AXI_N_MASTER        = 5;
    localparam int AXI_LOG_MASTER      = $clog2(AXI_N_MASTER);
    localparam int AXI_ID_WIDTH        = 20;
    localparam int AXI_AUX_WIDTH       = 64;
    localparam int AXI_MAX_OUTSTANDING = 8;
    localparam int AXI_CNT_WIDTH       = $clog2(AXI_MAX_OUTSTANDING + 1);

    // Master index occupies the bits directly above the master-side ID.
    localparam int IDX_LSB = AXI_ID_WIDTH;
    localparam int IDX_MSB = AXI_ID_WIDTH + AXI_LOG_MASTER - 1;

    // One response beat as held in the router output register.
    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]  id;
        logic [AXI_AUX_WIDTH-1:0] aux;
        logic                     last;
    } resp_beat_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } route_state_t;

    // Pull the originating master index out of a slave-side response ID.
    function automatic logic [AXI_LOG_MASTER-1:0] master_idx(
        input logic [AXI_ID_WIDTH+AXI_LOG_MASTER-1:0] id
    );
        return id[IDX_MSB:IDX_LSB];
    endfunction

endpackage

// File: rtl/axi_outstanding_cnt.sv
// Per-master outstanding transaction counter: saturating up/down with
// stall when full and a registered underflow pulse.
module axi_outstanding_cnt
    import axi_node_pkg::*;
#(
    parameter int MAX_OUTSTANDING = AXI_MAX_OUTSTANDING,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 stall_o,
    output logic                 underflow_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
    logic                 underflow_d, underflow_q;

    // Next count: issue and retire in the same cycle cancel; issue while full
    // saturates silently; retire at zero holds zero and flags underflow.
    always_comb begin
        cnt_d       = cnt_q;
        underflow_d = 1'b0;
        unique case ({inc_i, dec_i})
            2'b10: if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            2'b01: begin
                if (cnt_q == '0) underflow_d = 1'b1;
                else             cnt_d       = cnt_q - CNT_ONE;
            end
            default: ;
        endcase
    end

    // Counter and error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign stall_o     = (cnt_q == CNT_MAX);
    assign underflow_o = underflow_q;

endmodule

// File: rtl/axi_response_router.sv
// Routes a single slave response stream back to the originating master
// through a one-entry output register, stripping the master index from the
// ID and tracking outstanding transactions per master.
module axi_response_router
    import axi_node_pkg::*;
#(
    parameter int N_MASTER        = AXI_N_MASTER,
    parameter int LOG_MASTER      = $clog2(N_MASTER),
    parameter int ID_WIDTH        = AXI_ID_WIDTH,
    parameter int AUX_WIDTH       = AXI_AUX_WIDTH,
    parameter int MAX_OUTSTANDING = AXI_MAX_OUTSTANDING,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                resp_valid_i,
    input  logic [ID_WIDTH+LOG_MASTER-1:0]      resp_ID_i,
    input  logic [AUX_WIDTH-1:0]                resp_AUX_i,
    input  logic                                resp_last_i,
    output logic                                resp_ready_o,
    output logic [N_MASTER-1:0]                 data_valid_o,
    output logic [N_MASTER-1:0][ID_WIDTH-1:0]   data_ID_o,
    output logic [N_MASTER-1:0][AUX_WIDTH-1:0]  data_AUX_o,
    output logic [N_MASTER-1:0]                 data_last_o,
    input  logic [N_MASTER-1:0]                 data_ready_i,
    input  logic [N_MASTER-1:0]                 issue_i,
    output logic [N_MASTER-1:0]                 issue_stall_o,
    output logic                                err_route_o,
    output logic                                err_underflow_o
);

    route_state_t              state_d, state_q;
    logic [LOG_MASTER-1:0]     sel_d, sel_q;
    resp_beat_t                beat_d, beat_q;
    logic                      err_route_d, err_route_q;

    logic [LOG_MASTER-1:0]     idx;
    logic                      idx_ok;
    logic                      sel_ready;
    logic                      accept;
    logic [N_MASTER-1:0]       retire;
    logic [N_MASTER-1:0]       underflow;
    logic [N_MASTER-1:0][CNT_WIDTH-1:0] cnt;

    // Output register FSM and demux: valid is decoded one-hot from sel_q,
    // ID/payload/last are broadcast from the single register.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        beat_d      = beat_q;
        err_route_d = 1'b0;
        idx         = master_idx(resp_ID_i);
        idx_ok      = int'(idx) < N_MASTER;

        for (int m = 0; m < N_MASTER; m++) begin
            data_valid_o[m] = (state_q == ST_FULL) && (sel_q == LOG_MASTER'(m));
            data_ID_o[m]    = beat_q.id;
            data_AUX_o[m]   = beat_q.aux;
            data_last_o[m]  = beat_q.last;
        end

        // A held beat leaving lets a new beat enter in the same cycle.
        sel_ready    = |(data_valid_o & data_ready_i);
        resp_ready_o = (state_q == ST_EMPTY) || sel_ready;
        accept       = resp_valid_i && resp_ready_o;
        retire       = data_valid_o & data_ready_i & {N_MASTER{beat_q.last}};

        if (sel_ready) state_d = ST_EMPTY;
        if (accept) begin
            if (idx_ok) begin
                state_d = ST_FULL;
                sel_d   = idx;
                beat_d  = '{id: resp_ID_i[ID_WIDTH-1:0], aux: resp_AUX_i, last: resp_last_i};
            end else begin
                err_route_d = 1'b1;
            end
        end
    end

    // Router state, held beat and route error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            sel_q       <= '0;
            beat_q      <= '0;
            err_route_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            beat_q      <= beat_d;
            err_route_q <= err_route_d;
        end
    end

    for (genvar g = 0; g < N_MASTER; g++) begin : g_cnt
        axi_outstanding_cnt #(
            .MAX_OUTSTANDING (MAX_OUTSTANDING),
            .CNT_WIDTH       (CNT_WIDTH)
        ) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .inc_i       (issue_i[g]),
            .dec_i       (retire[g]),
            .cnt_o       (cnt[g]),
            .stall_o     (issue_stall_o[g]),
            .underflow_o (underflow[g])
        );
    end

    assign err_route_o     = err_route_q;
    assign err_underflow_o = |underflow;

endmodule

// File: tb/tb_axi_response_router.sv
// Scenario bench for axi_response_router with a delivery scoreboard.
module tb_axi_response_router;
    import axi_node_pkg::*;

    localparam int N  = 5;
    localparam int LM = 3;
    localparam int IW = 20;
    localparam int AW = 64;
    localparam int CW = 4;

    logic                    clk, rst;
    logic                    resp_valid_i;
    logic [IW+LM-1:0]        resp_ID_i;
    logic [AW-1:0]           resp_AUX_i;
    logic                    resp_last_i;
    logic                    resp_ready_o;
    logic [N-1:0]            data_valid_o;
    logic [N-1:0][IW-1:0]    data_ID_o;
    logic [N-1:0][AW-1:0]    data_AUX_o;
    logic [N-1:0]            data_last_o;
    logic [N-1:0]            data_ready_i;
    logic [N-1:0]            issue_i;
    logic [N-1:0]            issue_stall_o;
    logic                    err_route_o, err_underflow_o;

    typedef struct {
        int            m;
        logic [IW-1:0] id;
        logic [AW-1:0] aux;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    axi_response_router dut (
        .clk             (clk),
        .rst             (rst),
        .resp_valid_i    (resp_valid_i),
        .resp_ID_i       (resp_ID_i),
        .resp_AUX_i      (resp_AUX_i),
        .resp_last_i     (resp_last_i),
        .resp_ready_o    (resp_ready_o),
        .data_valid_o    (data_valid_o),
        .data_ID_o       (data_ID_o),
        .data_AUX_o      (data_AUX_o),
        .data_last_o     (data_last_o),
        .data_ready_i    (data_ready_i),
        .issue_i         (issue_i),
        .issue_stall_o   (issue_stall_o),
        .err_route_o     (err_route_o),
        .err_underflow_o (err_underflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every master-side handshake must match the oldest expected beat.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int m = 0; m < N; m++) begin
                if (data_valid_o[m] && data_ready_i[m]) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected: beat at master %0d with nothing expected", m);
                    end else begin
                        e = sb.pop_front();
                        if (e.m != m || data_ID_o[m] !== e.id || data_AUX_o[m] !== e.aux ||
                            data_last_o[m] !== e.last) begin
                            bad++;
                            $display("FAIL sb_beat: got m=%0d id=%h aux=%h last=%b, want m=%0d id=%h aux=%h last=%b",
                                     m, data_ID_o[m], data_AUX_o[m], data_last_o[m],
                                     e.m, e.id, e.aux, e.last);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_issue(input int m);
        issue_i[m] = 1'b1;
        tick();
        issue_i[m] = 1'b0;
    endtask

    // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send_beat(input int m, input logic [IW-1:0] id, input logic [AW-1:0] aux,
                             input logic last);
        int n;
        logic [LM-1:0] mi;
        mi           = LM'(m);
        resp_valid_i = 1'b1;
        resp_ID_i    = {mi, id};
        resp_AUX_i   = aux;
        resp_last_i  = last;
        if (m < N) sb.push_back('{m, id, aux, last});
        n = 0;
        @(negedge clk);
        while (!resp_ready_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!resp_ready_o) begin
            total++;
            bad++;
            $display("FAIL send_timeout: resp_ready_o=%b want 1 within 50 cycles", resp_ready_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        resp_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; resp_valid_i = 0; resp_ID_i = '0; resp_AUX_i = '0; resp_last_i = 0;
        data_ready_i = '1; issue_i = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (data_valid_o !== '0 || data_last_o !== '0) begin
            bad++; $display("FAIL reset_valid: valid=%b last=%b want 0", data_valid_o, data_last_o);
        end
        total++;
        if (data_ID_o !== '0 || data_AUX_o !== '0) begin
            bad++; $display("FAIL reset_data: id=%h aux=%h want 0", data_ID_o, data_AUX_o);
        end
        total++;
        if ({issue_stall_o, err_route_o, err_underflow_o, resp_ready_o} !== {5'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++; $display("FAIL reset_ctrl: stall=%b er=%b eu=%b rdy=%b want 0 0 0 1",
                            issue_stall_o, err_route_o, err_underflow_o, resp_ready_o);
        end
        tick();
    endtask

    task automatic test_single();
        pulse_issue(2);
        total++;
        if (dut.cnt[2] !== 4'd1) begin bad++; $display("FAIL single_cnt_up: cnt=%0d want 1", dut.cnt[2]); end
        send_beat(2, 20'h00ABC, 64'h1111_2222_3333_4444, 1'b1);
        idle();
        total++;
        if (data_valid_o !== 5'b00100 || data_ID_o[2] !== 20'h00ABC) begin
            bad++; $display("FAIL single_out: valid=%b id=%h want 00100 00abc", data_valid_o, data_ID_o[2]);
        end
        tick();
        total++;
        if (data_valid_o !== '0 || dut.cnt[2] !== 4'd0 || err_route_o !== 1'b0 || err_underflow_o !== 1'b0) begin
            bad++; $display("FAIL single_after: valid=%b cnt=%0d er=%b eu=%b want 0 0 0 0",
                            data_valid_o, dut.cnt[2], err_route_o, err_underflow_o);
        end
    endtask

    task automatic test_burst();
        int hs = 0;
        pulse_issue(0);
        fork
            begin
                for (int k = 0; k < 4; k++) send_beat(0, IW'(20'h100 + k), {$urandom, $urandom}, k == 3);
                idle();
            end
            begin
                for (int c = 0; c < 24; c++) begin
                    data_ready_i[0] = (c % 4 == 0) || (c % 4 == 3);
                    tick();
                end
                data_ready_i[0] = 1'b1;
            end
            begin
                logic [AW-1:0] paux;
                logic [IW-1:0] pid;
                logic          stalled = 1'b0;
                for (int c = 0; c < 24; c++) begin
                    @(negedge clk);
                    if (data_valid_o[0]) begin
                        total++;
                        if (dut.cnt[0] !== (hs < 4 ? 4'd1 : 4'd0)) begin
                            bad++; $display("FAIL burst_cnt: cnt=%0d want %0d", dut.cnt[0], hs < 4 ? 1 : 0);
                        end
                        if (stalled) begin
                            total++;
                            if (data_AUX_o[0] !== paux || data_ID_o[0] !== pid) begin
                                bad++; $display("FAIL burst_stable: aux=%h id=%h want %h %h",
                                                data_AUX_o[0], data_ID_o[0], paux, pid);
                            end
                        end
                        if (!data_ready_i[0]) begin
                            total++;
                            if (resp_ready_o !== 1'b0) begin
                                bad++; $display("FAIL burst_backpressure: resp_ready=%b want 0", resp_ready_o);
                            end
                        end
                        stalled = !data_ready_i[0];
                        paux    = data_AUX_o[0];
                        pid     = data_ID_o[0];
                        if (data_ready_i[0]) hs++;
                    end else begin
                        stalled = 1'b0;
                    end
                end
            end
        join
        total++;
        if (hs != 4 || dut.cnt[0] !== 4'd0) begin
            bad++; $display("FAIL burst_done: beats=%0d cnt=%0d want 4 0", hs, dut.cnt[0]);
        end
    endtask

    task automatic test_back_to_back();
        int ms[4] = '{1, 3, 4, 1};
        for (int k = 0; k < 4; k++) pulse_issue(ms[k]);
        fork
            begin
                for (int k = 0; k < 4; k++) send_beat(ms[k], IW'(20'h200 + k), {32'hB2B0_0000, 32'(k)}, 1'b1);
                idle();
            end
            begin
                int n = 0;
                logic [N-1:0] want;
                @(negedge clk);
                while (data_valid_o === '0 && n < 10) begin n++; @(negedge clk); end
                for (int k = 0; k < 4; k++) begin
                    want = N'(1) << ms[k];
                    total++;
                    if (data_valid_o !== want) begin
                        bad++; $display("FAIL b2b_valid%0d: valid=%b want %b", k, data_valid_o, want);
                    end
                    if (k < 3) @(negedge clk);
                end
            end
        join
        tick();
        total++;
        if (dut.cnt[1] !== 4'd0 || dut.cnt[3] !== 4'd0 || dut.cnt[4] !== 4'd0) begin
            bad++; $display("FAIL b2b_cnt: cnt1=%0d cnt3=%0d cnt4=%0d want 0", dut.cnt[1], dut.cnt[3], dut.cnt[4]);
        end
    endtask

    task automatic test_route_err();
        int errs = 0;
        int vals = 0;
        fork
            begin
                send_beat(6, 20'h00666, 64'h6, 1'b1);
                send_beat(7, 20'h00777, 64'h7, 1'b1);
                idle();
            end
            begin
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    if (err_route_o) errs++;
                    if (data_valid_o !== '0) vals++;
                end
            end
        join
        total++;
        if (errs != 2 || vals != 0) begin
            bad++; $display("FAIL route_err: pulses=%0d valid_cycles=%0d want 2 0", errs, vals);
        end
    endtask

    task automatic test_saturation();
        repeat (8) pulse_issue(4);
        total++;
        if (issue_stall_o[4] !== 1'b1 || dut.cnt[4] !== 4'd8) begin
            bad++; $display("FAIL sat_full: stall=%b cnt=%0d want 1 8", issue_stall_o[4], dut.cnt[4]);
        end
        pulse_issue(4);
        total++;
        if (dut.cnt[4] !== 4'd8 || err_underflow_o !== 1'b0 || err_route_o !== 1'b0) begin
            bad++; $display("FAIL sat_ninth: cnt=%0d eu=%b er=%b want 8 0 0", dut.cnt[4], err_underflow_o, err_route_o);
        end
        data_ready_i[4] = 1'b0;
        send_beat(4, 20'h00444, 64'h44, 1'b1);
        idle();
        issue_i[4]      = 1'b1;
        data_ready_i[4] = 1'b1;
        tick();
        issue_i[4] = 1'b0;
        total++;
        if (dut.cnt[4] !== 4'd8 || issue_stall_o[4] !== 1'b1 || data_valid_o !== '0) begin
            bad++; $display("FAIL sat_both: cnt=%0d stall=%b valid=%b want 8 1 0",
                            dut.cnt[4], issue_stall_o[4], data_valid_o);
        end
        send_beat(4, 20'h00445, 64'h45, 1'b1);
        idle();
        tick();
        total++;
        if (dut.cnt[4] !== 4'd7 || issue_stall_o[4] !== 1'b0) begin
            bad++; $display("FAIL sat_release: cnt=%0d stall=%b want 7 0", dut.cnt[4], issue_stall_o[4]);
        end
        for (int k = 0; k < 7; k++) send_beat(4, IW'(20'h00450 + k), 64'(k), 1'b1);
        idle();
        tick();
        total++;
        if (dut.cnt[4] !== 4'd0 || err_underflow_o !== 1'b0) begin
            bad++; $display("FAIL sat_drain: cnt=%0d eu=%b want 0 0", dut.cnt[4], err_underflow_o);
        end
    endtask

    task automatic test_underflow();
        send_beat(3, 20'h00333, 64'h33, 1'b1);
        idle();
        total++;
        if (data_valid_o !== 5'b01000 || err_underflow_o !== 1'b0) begin
            bad++; $display("FAIL uf_deliver: valid=%b eu=%b want 01000 0", data_valid_o, err_underflow_o);
        end
        tick();
        total++;
        if (err_underflow_o !== 1'b1 || dut.cnt[3] !== 4'd0) begin
            bad++; $display("FAIL uf_pulse: eu=%b cnt=%0d want 1 0", err_underflow_o, dut.cnt[3]);
        end
        tick();
        total++;
        if (err_underflow_o !== 1'b0) begin
            bad++; $display("FAIL uf_clear: eu=%b want 0", err_underflow_o);
        end
    endtask

    task automatic test_reset_mid();
        pulse_issue(2);
        pulse_issue(2);
        data_ready_i[1] = 1'b0;
        send_beat(1, 20'h00111, 64'h11, 1'b0);
        idle();
        total++;
        if (data_valid_o !== 5'b00010) begin
            bad++; $display("FAIL rstmid_held: valid=%b want 00010", data_valid_o);
        end
        rst = 1'b1;
        tick();
        total++;
        if (data_valid_o !== '0 || dut.cnt !== '0 || err_route_o !== 1'b0 || err_underflow_o !== 1'b0) begin
            bad++; $display("FAIL rstmid_clear: valid=%b cnt=%h er=%b eu=%b want 0 0 0 0",
                            data_valid_o, dut.cnt, err_route_o, err_underflow_o);
        end
        sb.delete();
        rst = 1'b0;
        data_ready_i = '1;
        tick();
        total++;
        if (resp_ready_o !== 1'b1 || data_valid_o !== '0) begin
            bad++; $display("FAIL rstmid_ready: rdy=%b valid=%b want 1 0", resp_ready_o, data_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_back_to_back();
        test_route_err();
        test_saturation();
        test_underflow();
        test_reset_mid();
        repeat (2) tick();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_leftover: pending=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
